// File: rtl/micro_run_pkg.sv
// Shared encodings for the micro core run/halt/step controller:
// FSM state codes and host command opcodes.
package micro_run_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    HALT     = 3'd1,
    RUN      = 3'd2,
    STEP     = 3'd3,
    BRK      = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_HALT  = 2'b01,
    OP_STEP  = 2'b10,
    OP_RESET = 2'b11
  } cmd_op_t;

endpackage

// File: rtl/micro_run_ctrl_if.sv
// Host command port of the run controller: valid/ready handshake carrying
// an opcode and a step count.
interface micro_run_ctrl_if #(
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] step_count;
  logic              cmd_ready;

  modport master (output cmd_valid, output cmd_op, output step_count, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  step_count, output cmd_ready);
endinterface

// File: rtl/micro_bp_match.sv
// Breakpoint comparator bank: one equality compare per enabled breakpoint
// against the core's current program-memory address.
module micro_bp_match #(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 2
) (
  input  logic [PC_W-1:0]        pm_address,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_valid,
  output logic [NUM_BP-1:0]      match
);

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_cmp
    assign match[gi] = bp_valid[gi] && (pm_address == bp_addr[gi*PC_W +: PC_W]);
  end

endmodule

// File: rtl/micro_run_ctrl.sv
// Run/halt/step/breakpoint controller for the 4-bit micro core.
// Optional enabled-cycle counter built only when MICRO_RUN_CYCLE_CNT_EN is defined.
module micro_run_ctrl
  import micro_run_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int NUM_BP     = 2,
  parameter int STEP_W     = 8,
  parameter int RST_CYCLES = 4,
  parameter int START_RUN  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  micro_run_ctrl_if.slave        cmd,
  input  logic [PC_W-1:0]        pm_address,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_valid,
  output logic                   cpu_en,
  output logic                   cpu_reset,
  output logic [2:0]             state,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [STEP_W-1:0]      steps_left,
  output logic [15:0]            cycle_count
);

  localparam int HOLD_W = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;

  run_state_t        state_reg;
  logic              cpu_en_reg;
  logic              cpu_reset_reg;
  logic              skip_reg;
  logic [NUM_BP-1:0] bp_hit_reg;
  logic [STEP_W-1:0] steps_left_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;

  logic [NUM_BP-1:0] match;
  logic              cmd_fire;
  logic              go_hold;
  logic              bp_fire;
  logic [STEP_W-1:0] step_load;

  micro_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pm_address (pm_address),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .match      (match)
  );

  assign cmd.cmd_ready = (state_reg != RST_HOLD);
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
  assign go_hold       = cmd_fire && (cmd.cmd_op == OP_RESET);
  // cpu_en_reg is only ever set in RUN/STEP; skip_reg masks the first enabled
  // cycle after a resume so the core can leave the address it stopped on.
  assign bp_fire       = cpu_en_reg && !skip_reg && (|match);
  assign step_load     = (cmd.step_count == '0) ? STEP_W'(1) : cmd.step_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= RST_HOLD;
      cpu_en_reg     <= 1'b0;
      cpu_reset_reg  <= 1'b1;
      skip_reg       <= 1'b0;
      bp_hit_reg     <= '0;
      steps_left_reg <= '0;
      hold_cnt_reg   <= '0;
    end else if (go_hold) begin
      state_reg      <= RST_HOLD;
      cpu_en_reg     <= 1'b0;
      cpu_reset_reg  <= 1'b1;
      skip_reg       <= 1'b0;
      steps_left_reg <= '0;
      hold_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        RST_HOLD: begin
          if (hold_cnt_reg == HOLD_W'(RST_CYCLES - 1)) begin
            hold_cnt_reg  <= '0;
            cpu_reset_reg <= 1'b0;
            if (START_RUN != 0) begin
              state_reg  <= RUN;
              cpu_en_reg <= 1'b1;
            end else begin
              state_reg  <= HALT;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        HALT, BRK: begin
          if (cmd_fire && (cmd.cmd_op == OP_RUN)) begin
            state_reg  <= RUN;
            cpu_en_reg <= 1'b1;
            skip_reg   <= 1'b1;
            bp_hit_reg <= '0;
          end else if (cmd_fire && (cmd.cmd_op == OP_STEP)) begin
            state_reg      <= STEP;
            cpu_en_reg     <= 1'b1;
            skip_reg       <= 1'b1;
            bp_hit_reg     <= '0;
            steps_left_reg <= step_load;
          end
        end
        RUN, STEP: begin
          skip_reg <= 1'b0;
          if (bp_fire) begin
            state_reg      <= BRK;
            cpu_en_reg     <= 1'b0;
            bp_hit_reg     <= bp_hit_reg | match;
            steps_left_reg <= '0;
          end else if (cmd_fire && (cmd.cmd_op == OP_HALT)) begin
            state_reg      <= HALT;
            cpu_en_reg     <= 1'b0;
            steps_left_reg <= '0;
          end else if (state_reg == STEP) begin
            steps_left_reg <= steps_left_reg - 1'b1;
            if (steps_left_reg == STEP_W'(1)) begin
              state_reg  <= HALT;
              cpu_en_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= RST_HOLD;
          cpu_en_reg    <= 1'b0;
          cpu_reset_reg <= 1'b1;
          hold_cnt_reg  <= '0;
        end
      endcase
    end
  end

`ifdef MICRO_RUN_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_reg <= '0;
    end else if (state_reg == RST_HOLD) begin
      cycle_cnt_reg <= '0;
    end else if (cpu_en_reg) begin
      cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
    end
  end

  assign cycle_count = cycle_cnt_reg;
`else
  assign cycle_count = '0;
`endif

  assign cpu_en     = cpu_en_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign state      = state_reg;
  assign halted     = (state_reg == HALT) || (state_reg == BRK);
  assign bp_hit     = bp_hit_reg;
  assign steps_left = steps_left_reg;

endmodule

// File: tb/tb_micro_run_ctrl.sv
// Self-checking bench for micro_run_ctrl: directed scenarios plus randomized
// RUN/STEP sessions predicted from the breakpoint/step rules.
module tb_micro_run_ctrl;
  import micro_run_pkg::*;

  localparam int PC_W   = 8;
  localparam int NUM_BP = 2;
  localparam int STEP_W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  micro_run_ctrl_if #(.STEP_W(STEP_W)) cmd_bus ();

  logic [PC_W-1:0]        pm_address = '0;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_valid;
  logic                   cpu_en;
  logic                   cpu_reset;
  logic [2:0]             state;
  logic                   halted;
  logic [NUM_BP-1:0]      bp_hit;
  logic [STEP_W-1:0]      steps_left;
  logic [15:0]            cycle_count;

  micro_run_ctrl #(
    .PC_W       (PC_W),
    .NUM_BP     (NUM_BP),
    .STEP_W     (STEP_W),
    .RST_CYCLES (4),
    .START_RUN  (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd         (cmd_bus.slave),
    .pm_address  (pm_address),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .cpu_en      (cpu_en),
    .cpu_reset   (cpu_reset),
    .state       (state),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .steps_left  (steps_left),
    .cycle_count (cycle_count)
  );

  // Stand-in core: program counter advances once per enabled cycle.
  always @(posedge clk) begin
    if (cpu_reset)   pm_address <= '0;
    else if (cpu_en) pm_address <= pm_address + 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [STEP_W-1:0] cnt);
    @(negedge clk);
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_op     = op;
    cmd_bus.step_count = cnt;
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid  = 1'b0;
  endtask

  // Counts enabled cycles until the controller stops in HALT or BRK.
  task automatic wait_stop(output int en_cycles, output logic timed_out);
    en_cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 600 && timed_out; i++) begin
      @(negedge clk);
      if (cpu_en) en_cycles++;
      if (halted) timed_out = 1'b0;
    end
  endtask

  task automatic wait_hold_exit(input string tag);
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 40 && timed_out; i++) begin
      @(negedge clk);
      if (state != 3'(RST_HOLD)) timed_out = 1'b0;
    end
    chk(tag, 32'(timed_out), 32'd0);
  endtask

  // Reference: the first enabled cycle is exempt from matching; every later
  // enabled cycle d sees address start+d. STEP stops after eff cycles anyway.
  function automatic void predict(input logic [PC_W-1:0] start, input logic is_run,
                                  input int eff, input logic [NUM_BP*PC_W-1:0] addrs,
                                  input logic [NUM_BP-1:0] valid, output int cyc,
                                  output logic [NUM_BP-1:0] hit, output logic brk);
    int lim;
    logic [PC_W-1:0] a;
    logic [NUM_BP-1:0] m;
    brk = 1'b0;
    hit = '0;
    cyc = eff;
    lim = is_run ? 256 : eff - 1;
    for (int d = 1; d <= lim && !brk; d++) begin
      a = start + PC_W'(d);
      for (int k = 0; k < NUM_BP; k++)
        m[k] = valid[k] && (addrs[k*PC_W +: PC_W] == a);
      if (m != '0) begin
        brk = 1'b1;
        hit = m;
        cyc = d + 1;
      end
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, en, cyc, eff, exp_cc;
    logic to, brk, is_run, found;
    logic [PC_W-1:0] exp_pm, a0, a1;
    logic [NUM_BP-1:0] vld, hit;
    logic [STEP_W-1:0] cnt;

    reset_n = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op = 2'b00;
    cmd_bus.step_count = '0;
    bp_addr = '0;
    bp_valid = '0;
    repeat (2) @(negedge clk);

    chk("rst_state", 32'(state), 32'(RST_HOLD));
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_steps_left", 32'(steps_left), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);

    // cpu_reset must stay high for exactly four edges after release.
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cpu_reset) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("hold_edges", 32'(n), 32'd4);
    @(negedge clk);
    chk("post_hold_state", 32'(state), 32'(HALT));
    chk("post_hold_cpu_en", 32'(cpu_en), 32'd0);
    chk("post_hold_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    chk("post_hold_halted", 32'(halted), 32'd1);
    exp_pm = '0;
    chk("post_hold_pm", 32'(pm_address), 32'(exp_pm));

    // STEP 3: steps_left 3,2,1,0 with exactly three enabled cycles.
    send_cmd(OP_STEP, 8'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("step3_left_%0d", k), 32'(steps_left), 32'(3 - k));
      chk($sformatf("step3_en_%0d", k), 32'(cpu_en), 32'(k < 3));
    end
    chk("step3_state", 32'(state), 32'(HALT));
    exp_pm = 8'd3;
    chk("step3_pm", 32'(pm_address), 32'(exp_pm));
    $display("step3: pm=%0h state=%0d", pm_address, state);

    // RUN into breakpoint 0 at 0x05.
    bp_addr = {8'h00, 8'h05};
    bp_valid = 2'b01;
    send_cmd(OP_RUN, 8'd0);
    wait_stop(en, to);
    chk("bp5_timeout", 32'(to), 32'd0);
    chk("bp5_cycles", 32'(en), 32'd3);
    chk("bp5_state", 32'(state), 32'(BRK));
    chk("bp5_bp_hit", 32'(bp_hit), 32'b01);
    chk("bp5_pm", 32'(pm_address), 32'h06);
    $display("run->brk: pm=%0h bp_hit=%b", pm_address, bp_hit);

    send_cmd(OP_STEP, 8'd1);
    wait_stop(en, to);
    chk("step1_cycles", 32'(en), 32'd1);
    chk("step1_state", 32'(state), 32'(HALT));
    chk("step1_bp_hit", 32'(bp_hit), 32'd0);
    chk("step1_pm", 32'(pm_address), 32'h07);

    // Resume skip: bp0 sits on the current address, bp1 two ahead.
    bp_addr = {8'h09, 8'h07};
    bp_valid = 2'b11;
    send_cmd(OP_RUN, 8'd0);
    wait_stop(en, to);
    chk("skip_cycles", 32'(en), 32'd3);
    chk("skip_state", 32'(state), 32'(BRK));
    chk("skip_bp_hit", 32'(bp_hit), 32'b10);
    chk("skip_pm", 32'(pm_address), 32'h0a);

    send_cmd(OP_HALT, 8'd0);
    @(negedge clk);
    chk("halt_in_brk_ignored", 32'(state), 32'(BRK));

    // RESET command; a RUN offered during the hold must be ignored.
    send_cmd(OP_RESET, 8'd0);
    chk("rstcmd_state", 32'(state), 32'(RST_HOLD));
    chk("rstcmd_cpu_reset", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op = OP_RUN;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    wait_hold_exit("rstcmd_hold_timeout");
    chk("rstcmd_exit_state", 32'(state), 32'(HALT));
    chk("rstcmd_bp_hit_kept", 32'(bp_hit), 32'b10);
    chk("rstcmd_cycle_count", 32'(cycle_count), 32'd0);
    exp_pm = '0;
    chk("rstcmd_pm", 32'(pm_address), 32'(exp_pm));

    // RUN for exactly 20 enabled cycles, then HALT.
    bp_valid = '0;
    send_cmd(OP_RUN, 8'd0);
    n = 0;
    for (int i = 0; i < 100 && n < 20; i++) begin
      @(negedge clk);
      if (cpu_en) n++;
      if (n == 20) begin
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op = OP_HALT;
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("run20_en_seen", 32'(n), 32'd20);
    chk("run20_state", 32'(state), 32'(HALT));
    chk("run20_cpu_en", 32'(cpu_en), 32'd0);
    chk("run20_steps_left", 32'(steps_left), 32'd0);
`ifdef MICRO_RUN_CYCLE_CNT_EN
    exp_cc = 20;
`else
    exp_cc = 0;
`endif
    chk("run20_cycle_count", 32'(cycle_count), 32'(exp_cc));
    exp_pm = 8'd20;
    chk("run20_pm", 32'(pm_address), 32'(exp_pm));

    // RESET command lands on the same edge as a breakpoint match.
    bp_addr = {8'h00, 8'd25};
    bp_valid = 2'b01;
    send_cmd(OP_RUN, 8'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (cpu_en && pm_address == 8'd25) begin
        found = 1'b1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op = OP_RESET;
        @(posedge clk);
        #1;
        cmd_bus.cmd_valid = 1'b0;
      end
    end
    chk("race_found", 32'(found), 32'd1);
    chk("race_state", 32'(state), 32'(RST_HOLD));
    chk("race_bp_hit", 32'(bp_hit), 32'd0);
    chk("race_cpu_en", 32'(cpu_en), 32'd0);
    wait_hold_exit("race_hold_timeout");

    // Asynchronous reset in the middle of a STEP burst.
    bp_valid = '0;
    send_cmd(OP_STEP, 8'd10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (steps_left == 8'd7) found = 1'b1;
    end
    chk("astep_found", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_cpu_en", 32'(cpu_en), 32'd0);
    chk("areset_steps_left", 32'(steps_left), 32'd0);
    chk("areset_state", 32'(state), 32'(RST_HOLD));
    chk("areset_cpu_reset", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_hold_exit("areset_hold_timeout");
    exp_pm = '0;
    chk("areset_pm", 32'(pm_address), 32'(exp_pm));

    // Randomized RUN/STEP sessions against the reference rules.
    for (int t = 0; t < 14; t++) begin
      is_run = ($urandom_range(0, 2) == 0);
      a0 = exp_pm + PC_W'($urandom_range(0, 12));
      a1 = exp_pm + PC_W'($urandom_range(0, 12));
      vld = NUM_BP'($urandom_range(0, 3));
      if (is_run) vld[0] = 1'b1;
      cnt = STEP_W'($urandom_range(0, 10));
      eff = (cnt == '0) ? 1 : int'(cnt);
      bp_addr = {a1, a0};
      bp_valid = vld;
      predict(exp_pm, is_run, eff, {a1, a0}, vld, cyc, hit, brk);
      send_cmd(is_run ? OP_RUN : OP_STEP, cnt);
      wait_stop(en, to);
      chk($sformatf("rnd%0d_timeout", t), 32'(to), 32'd0);
      chk($sformatf("rnd%0d_cycles", t), 32'(en), 32'(cyc));
      chk($sformatf("rnd%0d_state", t), 32'(state), brk ? 32'(BRK) : 32'(HALT));
      chk($sformatf("rnd%0d_bp_hit", t), 32'(bp_hit), 32'(hit));
      chk($sformatf("rnd%0d_steps_left", t), 32'(steps_left), 32'd0);
      exp_pm = exp_pm + PC_W'(cyc);
      chk($sformatf("rnd%0d_pm", t), 32'(pm_address), 32'(exp_pm));
      $display("rnd%0d: %s cnt=%0d bp=%h/%h v=%b -> cycles=%0d brk=%0d hit=%b",
               t, is_run ? "RUN" : "STEP", cnt, a1, a0, vld, en, brk, bp_hit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
